imem_loader: RTL and testbench
==============================

# imem_loader

Byte-stream writer that fills the byte-wide, big-endian instruction memory before execution; it is the write-side counterpart of the PC-driven instruction fetch. Accepts bytes over a valid/ready handshake, writes them to consecutive byte addresses from 0, and verifies a trailing XOR checksum. Holds the CPU (PC) in reset while loading, then releases it.

## Interface
- ADDR_W, default 10: byte-address width of instruction memory (1024 bytes).
- LEN_W, default ADDR_W-1: width of the word-count input.
- CLK  in  1  system clock; all state changes on posedge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  begin a load; sampled only in IDLE.
- LEN  in  LEN_W  number of 32-bit words to load; values above 2^(ADDR_W-2) saturate to 2^(ADDR_W-2).
- BYTE_IN  in  8  incoming byte, MSB-first per word.
- BYTE_VALID  in  1  BYTE_IN valid.
- BYTE_READY  out  1  loader accepts a byte this cycle.
- MEM_WE  out  1  instruction-memory byte write enable.
- MEM_ADDR  out  ADDR_W  byte address.
- MEM_DATA  out  8  byte to write.
- CPU_HOLD  out  1  keep PC/fetch in reset (OR with RESET at the top level).
- BUSY  out  1  load in progress.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  checksum mismatch; sticky until next accepted START or RESET.

## Operation
- States: IDLE, LOAD, CHECK, DONE.
- IDLE: BYTE_READY=0, CPU_HOLD=0. START=1 -> latch saturated LEN, clear byte counter and checksum, clear ERR; next state LOAD, or CHECK if LEN=0.
- LEN latched at START; changes to LEN during a load are ignored.
- LOAD: BYTE_READY=1. A byte is accepted when BYTE_VALID && BYTE_READY. Per accepted byte: checksum ^= byte, counter += 1, registered write of (counter, byte). After byte 4*LEN is accepted -> CHECK.
- CHECK: BYTE_READY=1. Next accepted byte is the checksum; ERR <= (byte != checksum); no memory write -> DONE.
- DONE: DONE=1, CPU_HOLD=1, BYTE_READY=0 for one cycle -> IDLE.
- Byte order: byte k of word w goes to address 4w+k; k=0 is bits [31:24] of the instruction.
- Counter is ADDR_W+1 bits internally; MEM_ADDR is its low ADDR_W bits. A maximum-length load ends at address 2^ADDR_W-1 with no wrap.
- START outside IDLE is ignored.
- BYTE_VALID in IDLE/DONE is ignored; no byte consumed.
- RESET during any state: IDLE on the next edge, all outputs 0. Memory contents already written are not cleared.

## Timing
- Reset values: BYTE_READY, MEM_WE, MEM_ADDR, MEM_DATA, CPU_HOLD, BUSY, DONE, ERR all 0; state IDLE.
- START at edge t: BUSY and CPU_HOLD are 1 from t+1 through the DONE cycle inclusive.
- Write latency: byte accepted at edge t -> MEM_WE=1 with MEM_ADDR/MEM_DATA during cycle t+1 -> t+2. MEM_WE=0 when no byte was accepted on the previous edge.
- BYTE_READY is a combinational decode of state; throughput is one byte per cycle with no bubbles.
- The last data byte and the checksum byte may be on consecutive edges.
- ERR is valid from the DONE cycle onward.
- Minimum load time (LEN=n): 4n+2 cycles from START to return to IDLE, plus the write drain.

## Structure
- Shared package holds:
  - state encoding: S_IDLE=0, S_LOAD=1, S_CHECK=2, S_DONE=3, 2-bit type;
  - BYTE_W=8;
  - the instruction-memory size constant, shared with the instruction memory.
- Single module; the checksum and counter are simple enough to stay inline. No sub-module.
- The instruction memory gains a byte write port (MEM_WE/MEM_ADDR/MEM_DATA) written on posedge CLK.

## Test plan
- Reset, START with LEN=1, bytes 08 01 10 00, checksum 19 -> writes addr0..3 = 08,01,10,00; DONE pulses once; ERR=0; CPU_HOLD falls after DONE.
- Same load with checksum 00 -> same four writes; DONE pulses; ERR=1 and stays 1 until the next START.
- LEN=2 with BYTE_VALID toggled every other cycle -> exactly 8 writes at contiguous addresses 0..7; no MEM_WE in gap cycles.
- LEN=0, checksum byte 00 -> no MEM_WE; ERR=0; DONE two cycles after CHECK entry plus byte arrival.
- RESET asserted after 2 bytes accepted -> next cycle IDLE with all outputs 0; a new START restarts at address 0 with checksum 0.
- START pulsed during LOAD is ignored. LEN=300 saturates to 256 -> last write at address 1023, then CHECK.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction-memory loader
// Purpose: FSM state encoding, byte width and instruction-memory size shared by
//          the loader and the instruction memory.
// Ports:   none (package).
package imem_loader_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam int BYTE_W      = 8;
    localparam int IMEM_ADDR_W = 10;
    localparam int IMEM_BYTES  = 1 << IMEM_ADDR_W;

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream writer that fills instruction memory and checks an XOR checksum
// Purpose: accepts 4*LEN bytes over a valid/ready handshake, writes them to consecutive
//          byte addresses from 0 (big-endian words), then compares one trailing XOR
//          checksum byte. Holds the CPU in reset for the whole load.
// Ports:
//   CLK, RESET        clock, synchronous active-high reset
//   START, LEN        begin a load of LEN 32-bit words (sampled in IDLE only)
//   BYTE_IN/VALID     incoming byte stream; BYTE_READY = loader can accept
//   MEM_WE/ADDR/DATA  registered byte write port into instruction memory
//   CPU_HOLD, BUSY    load in progress (CPU held in reset)
//   DONE              one-cycle completion pulse
//   ERR               sticky checksum mismatch until next START or RESET
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int LEN_W  = ADDR_W - 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [LEN_W-1:0]  LEN,
    input  logic [BYTE_W-1:0] BYTE_IN,
    input  logic              BYTE_VALID,
    output logic              BYTE_READY,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [BYTE_W-1:0] MEM_DATA,
    output logic              CPU_HOLD,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

    // One extra counter bit so a full-memory load can count to 2^ADDR_W without wrapping.
    localparam int          CNT_W   = ADDR_W + 1;
    localparam int unsigned LEN_MAX = 1 << (ADDR_W - 2);

    state_e              state_q;
    logic [ADDR_W-2:0]   len_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [BYTE_W-1:0]   csum_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [BYTE_W-1:0]   mem_data_q;
    logic                cpu_hold_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    logic [31:0]         len_ext;
    logic [ADDR_W-2:0]   len_sat_d;
    logic [CNT_W-1:0]    cnt_d;
    logic [CNT_W-1:0]    end_cnt;

    // Word count saturates at the memory capacity in words.
    always_comb begin
        len_ext   = 32'(LEN);
        len_sat_d = (len_ext > LEN_MAX) ? (ADDR_W-1)'(LEN_MAX) : (ADDR_W-1)'(len_ext);
    end

    assign cnt_d   = cnt_q + CNT_W'(1);
    assign end_cnt = {len_q, 2'b00};

    // Ready is a pure state decode so a byte can be taken every cycle.
    assign BYTE_READY = (state_q == S_LOAD) || (state_q == S_CHECK);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            csum_q     <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            cpu_hold_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        len_q      <= len_sat_d;
                        cnt_q      <= '0;
                        csum_q     <= '0;
                        err_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        cpu_hold_q <= 1'b1;
                        state_q    <= (len_sat_d == '0) ? S_CHECK : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (BYTE_VALID) begin
                        csum_q     <= csum_q ^ BYTE_IN;
                        cnt_q      <= cnt_d;
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= cnt_q[ADDR_W-1:0];
                        mem_data_q <= BYTE_IN;
                        if (cnt_d == end_cnt) begin
                            state_q <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (BYTE_VALID) begin
                        err_q   <= (BYTE_IN != csum_q);
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q     <= 1'b0;
                    cpu_hold_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign MEM_WE   = mem_we_q;
    assign MEM_ADDR = mem_addr_q;
    assign MEM_DATA = mem_data_q;
    assign CPU_HOLD = cpu_hold_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign ERR      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic        CLK;
    logic        RESET;
    logic        START;
    logic [8:0]  LEN;
    logic [7:0]  BYTE_IN;
    logic        BYTE_VALID;
    logic        BYTE_READY;
    logic        MEM_WE;
    logic [9:0]  MEM_ADDR;
    logic [7:0]  MEM_DATA;
    logic        CPU_HOLD;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int wr_base;
    logic [7:0] mem [0:IMEM_BYTES-1];

    imem_loader dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .START      (START),
        .LEN        (LEN),
        .BYTE_IN    (BYTE_IN),
        .BYTE_VALID (BYTE_VALID),
        .BYTE_READY (BYTE_READY),
        .MEM_WE     (MEM_WE),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_DATA   (MEM_DATA),
        .CPU_HOLD   (CPU_HOLD),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .ERR        (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (MEM_WE) begin
            mem[MEM_ADDR] <= MEM_DATA;
            wr_cnt        <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic send(input logic [7:0] b);
        BYTE_VALID = 1'b1;
        BYTE_IN    = b;
        @(negedge CLK);
        BYTE_VALID = 1'b0;
    endtask

    task automatic chk_wr(input string tag, input logic [9:0] a, input logic [7:0] d);
        chk({tag, "_we"}, 32'(MEM_WE), 32'd1);
        chk({tag, "_addr"}, 32'(MEM_ADDR), 32'(a));
        chk({tag, "_data"}, 32'(MEM_DATA), 32'(d));
    endtask

    task automatic start_load(input logic [8:0] n);
        START = 1'b1;
        LEN   = n;
        step();
        START = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; START = 1'b0; LEN = '0; BYTE_IN = '0; BYTE_VALID = 1'b0;
        step(); step();

        // reset state
        chk("rst_ready", 32'(BYTE_READY), 0);
        chk("rst_we",    32'(MEM_WE), 0);
        chk("rst_addr",  32'(MEM_ADDR), 0);
        chk("rst_data",  32'(MEM_DATA), 0);
        chk("rst_hold",  32'(CPU_HOLD), 0);
        chk("rst_busy",  32'(BUSY), 0);
        chk("rst_done",  32'(DONE), 0);
        chk("rst_err",   32'(ERR), 0);
        RESET = 1'b0;
        step();

        // a byte offered in IDLE is not consumed
        send(8'h5A);
        chk("idle_we",   32'(MEM_WE), 0);
        chk("idle_busy", 32'(BUSY), 0);

        // test 1: LEN=1, good checksum
        wr_base = wr_cnt;
        start_load(9'd1);
        chk("t1_busy",  32'(BUSY), 1);
        chk("t1_hold",  32'(CPU_HOLD), 1);
        chk("t1_ready", 32'(BYTE_READY), 1);
        chk("t1_we0",   32'(MEM_WE), 0);
        send(8'h08); chk_wr("t1_b0", 10'd0, 8'h08);
        send(8'h01); chk_wr("t1_b1", 10'd1, 8'h01);
        send(8'h10); chk_wr("t1_b2", 10'd2, 8'h10);
        send(8'h00); chk_wr("t1_b3", 10'd3, 8'h00);
        chk("t1_chk_ready", 32'(BYTE_READY), 1);
        chk("t1_chk_done",  32'(DONE), 0);
        send(8'h19);
        chk("t1_done",       32'(DONE), 1);
        chk("t1_err",        32'(ERR), 0);
        chk("t1_done_hold",  32'(CPU_HOLD), 1);
        chk("t1_done_busy",  32'(BUSY), 1);
        chk("t1_done_ready", 32'(BYTE_READY), 0);
        chk("t1_done_we",    32'(MEM_WE), 0);
        step();
        chk("t1_done_fall", 32'(DONE), 0);
        chk("t1_hold_fall", 32'(CPU_HOLD), 0);
        chk("t1_busy_fall", 32'(BUSY), 0);
        chk("t1_writes",    32'(wr_cnt - wr_base), 4);
        chk("t1_mem", {mem[0], mem[1], mem[2], mem[3]}, 32'h08011000);

        // test 2: same load, bad checksum
        wr_base = wr_cnt;
        start_load(9'd1);
        send(8'h08); send(8'h01); send(8'h10); send(8'h00);
        send(8'h00);
        chk("t2_done", 32'(DONE), 1);
        chk("t2_err",  32'(ERR), 1);
        step();
        chk("t2_err_sticky1", 32'(ERR), 1);
        step();
        chk("t2_err_sticky2", 32'(ERR), 1);
        chk("t2_writes", 32'(wr_cnt - wr_base), 4);

        // test 3: LEN=2, valid every other cycle
        wr_base = wr_cnt;
        start_load(9'd2);
        chk("t3_err_clr", 32'(ERR), 0);
        for (int i = 0; i < 8; i++) begin
            send(8'hA0 + 8'(i));
            chk_wr("t3_wr", 10'(i), 8'hA0 + 8'(i));
            step();
            chk("t3_gap_we", 32'(MEM_WE), 0);
        end
        chk("t3_ready_chk", 32'(BYTE_READY), 1);
        send(8'h00);
        chk("t3_done",   32'(DONE), 1);
        chk("t3_err",    32'(ERR), 0);
        chk("t3_writes", 32'(wr_cnt - wr_base), 8);
        step();

        // test 4: LEN=0 goes straight to CHECK
        wr_base = wr_cnt;
        start_load(9'd0);
        chk("t4_ready", 32'(BYTE_READY), 1);
        chk("t4_busy",  32'(BUSY), 1);
        step();
        chk("t4_wait_done", 32'(DONE), 0);
        send(8'h00);
        chk("t4_done",   32'(DONE), 1);
        chk("t4_err",    32'(ERR), 0);
        chk("t4_we",     32'(MEM_WE), 0);
        step();
        chk("t4_writes", 32'(wr_cnt - wr_base), 0);
        chk("t4_idle",   32'(BUSY), 0);

        // test 5: reset mid-load, then restart from address 0 and checksum 0
        start_load(9'd1);
        send(8'h11); send(8'h22);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        chk("t5_ready", 32'(BYTE_READY), 0);
        chk("t5_we",    32'(MEM_WE), 0);
        chk("t5_addr",  32'(MEM_ADDR), 0);
        chk("t5_data",  32'(MEM_DATA), 0);
        chk("t5_hold",  32'(CPU_HOLD), 0);
        chk("t5_busy",  32'(BUSY), 0);
        start_load(9'd1);
        send(8'h33); chk_wr("t5_b0", 10'd0, 8'h33);
        send(8'h44); send(8'h55); send(8'h66);
        chk_wr("t5_b3", 10'd3, 8'h66);
        send(8'h44);
        chk("t5_done", 32'(DONE), 1);
        chk("t5_err",  32'(ERR), 0);
        step();

        // test 6: LEN=300 saturates to 256 words; START during LOAD ignored
        wr_base = wr_cnt;
        start_load(9'd300);
        for (int i = 0; i < 1024; i++) begin
            if (i == 10) begin
                START = 1'b1;
                LEN   = 9'd1;
            end
            send(8'(i));
            START = 1'b0;
        end
        chk_wr("t6_last", 10'd1023, 8'hFF);
        chk("t6_ready_chk", 32'(BYTE_READY), 1);
        chk("t6_not_done",  32'(DONE), 0);
        chk("t6_writes",    32'(wr_cnt - wr_base + 1), 1024);
        send(8'h00);
        chk("t6_done",  32'(DONE), 1);
        chk("t6_err",   32'(ERR), 0);
        chk("t6_we",    32'(MEM_WE), 0);
        chk("t6_mem10", 32'(mem[10]), 32'h0A);
        chk("t6_mem1023", 32'(mem[1023]), 32'hFF);
        step();
        chk("t6_idle", 32'(BUSY), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
